id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-select stage of the MIPS core, sitting directly upstream of `alu`. It captures decoded instruction fields and register-file reads each cycle and applies EX/MEM and MEM/WB forwarding. It builds the final `a`, `b` and `aluc` the ALU consumes, and passes memory/writeback control to EX/MEM. It also raises the load-use stall request back to decode.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/fwd_mux.sv | 27 ++
 rtl/id_ex_stage.sv | 124 ++++++++++++
 tb/tb_id_ex_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: ALU op codes, ID/EX bundle, bubble value.
package mips_pkg;

  localparam logic [3:0] ALUC_ADDU = 4'b0000;
  localparam logic [3:0] ALUC_ADD  = 4'b0010;
  localparam logic [3:0] ALUC_SRA  = 4'b1100;
  localparam logic [3:0] ALUC_SRL  = 4'b1101;
  localparam logic [3:0] ALUC_SLL  = 4'b1110;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic [3:0]  aluc;
    logic        alu_src_imm;
    logic        imm_sext;
    logic        shift_var;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

  function automatic logic is_shift_op(input logic [3:0] aluc);
    return (aluc == ALUC_SRA) || (aluc == ALUC_SRL) || (aluc == ALUC_SLL);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX/MEM beats MEM/WB beats register file.
module fwd_mux
  import mips_pkg::*;
(
  input  logic [4:0]  reg_num,
  input  logic [31:0] reg_val,
  input  logic        exm_reg_write,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        mwb_reg_write,
  input  logic [4:0]  mwb_rd,
  input  logic [31:0] mwb_result,
  output logic [31:0] fwd_val
);

  logic nz;

  always_comb begin
    nz      = (reg_num != 5'd0);
    fwd_val = reg_val;
    if (exm_reg_write && exm_rd == reg_num && nz)
      fwd_val = exm_result;
    else if (mwb_reg_write && mwb_rd == reg_num && nz)
      fwd_val = mwb_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding, ALU operand build
// and load-use hazard detection.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [15:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic [3:0]  id_aluc,
  input  logic        id_alu_src_imm,
  input  logic        id_imm_sext,
  input  logic        id_shift_var,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        exm_reg_write,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        mwb_reg_write,
  input  logic [4:0]  mwb_rd,
  input  logic [31:0] mwb_result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_store_data,
  output logic        load_use_stall
);

  id_ex_t stage_d, stage_q;
  logic [31:0] fwd_rs, fwd_rt;

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = ID_EX_BUBBLE;
    end else if (!stall) begin
      stage_d.valid       = id_valid;
      stage_d.reg_write   = id_reg_write;
      stage_d.mem_read    = id_mem_read;
      stage_d.mem_write   = id_mem_write;
      stage_d.rs_val      = id_rs_val;
      stage_d.rt_val      = id_rt_val;
      stage_d.rs          = id_rs;
      stage_d.rt          = id_rt;
      stage_d.rd          = id_rd;
      stage_d.imm         = id_imm;
      stage_d.shamt       = id_shamt;
      stage_d.aluc        = id_aluc;
      stage_d.alu_src_imm = id_alu_src_imm;
      stage_d.imm_sext    = id_imm_sext;
      stage_d.shift_var   = id_shift_var;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= ID_EX_BUBBLE;
    else     stage_q <= stage_d;
  end

  fwd_mux u_fwd_rs (
    .reg_num       (stage_q.rs),
    .reg_val       (stage_q.rs_val),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .fwd_val       (fwd_rs)
  );

  fwd_mux u_fwd_rt (
    .reg_num       (stage_q.rt),
    .reg_val       (stage_q.rt_val),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .fwd_val       (fwd_rt)
  );

  // The ALU shifts by all of a, so variable shift amounts are masked here.
  always_comb begin
    alu_a = fwd_rs;
    if (is_shift_op(stage_q.aluc))
      alu_a = stage_q.shift_var ? {27'b0, fwd_rs[4:0]}
                                : {27'b0, stage_q.shamt};
  end

  always_comb begin
    alu_b = fwd_rt;
    if (stage_q.alu_src_imm)
      alu_b = {{16{stage_q.imm[15] & stage_q.imm_sext}}, stage_q.imm};
  end

  assign alu_aluc      = stage_q.aluc;
  assign ex_valid      = stage_q.valid;
  assign ex_reg_write  = stage_q.reg_write;
  assign ex_mem_read   = stage_q.mem_read;
  assign ex_mem_write  = stage_q.mem_write;
  assign ex_rd         = stage_q.rd;
  assign ex_store_data = fwd_rt;

  assign load_use_stall = id_valid && stage_q.valid && stage_q.mem_read
                       && (stage_q.rd != 5'd0)
                       && (stage_q.rd == id_rs || stage_q.rd == id_rt);

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: reference model, directed
// scenarios and randomized traffic.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_rs_val, id_rt_val;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm;
  logic [4:0]  id_shamt;
  logic [3:0]  id_aluc;
  logic        id_alu_src_imm, id_imm_sext, id_shift_var;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        exm_reg_write, mwb_reg_write;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_aluc;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;
  logic        load_use_stall;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_aluc(id_aluc),
    .id_alu_src_imm(id_alu_src_imm), .id_imm_sext(id_imm_sext),
    .id_shift_var(id_shift_var), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
    .exm_result(exm_result), .mwb_reg_write(mwb_reg_write),
    .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .load_use_stall(load_use_stall)
  );

  typedef struct {
    bit v, rw, mr, mw, src, sext, svar;
    int unsigned rsv, rtv, rs, rt, rd, imm, shamt, aluc;
  } instr_t;

  typedef struct {
    logic [31:0] a, b, sd;
    logic [3:0]  aluc;
    logic        v, rw, mr, mw, lus;
    logic [4:0]  rd;
  } exp_t;

  instr_t held;
  exp_t   q[$];
  exp_t   me;
  int     n_chk = 0;
  int     n_fail = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic instr_t bubble();
    instr_t t;
    t = '{default: 0};
    return t;
  endfunction

  function automatic instr_t capture();
    instr_t t;
    t.v = id_valid; t.rw = id_reg_write;
    t.mr = id_mem_read; t.mw = id_mem_write;
    t.src = id_alu_src_imm; t.sext = id_imm_sext; t.svar = id_shift_var;
    t.rsv = id_rs_val; t.rtv = id_rt_val;
    t.rs = 32'(id_rs); t.rt = 32'(id_rt); t.rd = 32'(id_rd);
    t.imm = 32'(id_imm); t.shamt = 32'(id_shamt); t.aluc = 32'(id_aluc);
    return t;
  endfunction

  function automatic int unsigned fwd(input int unsigned r,
                                      input int unsigned v);
    if (exm_reg_write && 32'(exm_rd) == r && r != 0) return exm_result;
    if (mwb_reg_write && 32'(mwb_rd) == r && r != 0) return mwb_result;
    return v;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    int unsigned fr, ft;
    fr = fwd(held.rs, held.rsv);
    ft = fwd(held.rt, held.rtv);
    if (held.aluc >= 12 && held.aluc <= 14)
      e.a = held.svar ? fr % 32 : held.shamt;
    else
      e.a = fr;
    if (held.src)
      e.b = (held.sext && held.imm >= 32768) ? held.imm + 32'hFFFF_0000
                                            : held.imm;
    else
      e.b = ft;
    e.sd = ft;
    e.aluc = 4'(held.aluc);
    e.v = held.v; e.rw = held.rw; e.mr = held.mr; e.mw = held.mw;
    e.rd = 5'(held.rd);
    e.lus = id_valid && held.v && held.mr && held.rd != 0 &&
            (held.rd == 32'(id_rs) || held.rd == 32'(id_rt));
    return e;
  endfunction

  // Model update at the edge, then inputs may change 1 unit later.
  task automatic tick();
    @(posedge clk);
    if (rst || flush) held = bubble();
    else if (!stall)  held = capture();
    #1;
  endtask

  task automatic push();
    if (rst) held = bubble();
    q.push_back(expect_now());
  endtask

  task automatic clear_inputs();
    rst = 0; stall = 0; flush = 0; id_valid = 0;
    id_rs_val = 0; id_rt_val = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_imm = 0; id_shamt = 0; id_aluc = 0;
    id_alu_src_imm = 0; id_imm_sext = 0; id_shift_var = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
  endtask

  task automatic rand_id();
    logic [3:0] ops [6];
    ops = '{4'd0, 4'd2, 4'd5, 4'd12, 4'd13, 4'd14};
    id_valid = 1'($urandom_range(0, 1));
    id_rs_val = $urandom; id_rt_val = $urandom;
    id_rs = 5'($urandom_range(0, 3));
    id_rt = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom_range(0, 3));
    id_imm = 16'($urandom); id_shamt = 5'($urandom);
    id_aluc = ops[$urandom_range(0, 5)];
    id_alu_src_imm = 1'($urandom); id_imm_sext = 1'($urandom);
    id_shift_var = 1'($urandom);
    id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
    id_mem_write = 1'($urandom);
  endtask

  task automatic rand_inputs();
    rand_id();
    rst = ($urandom_range(0, 99) == 0);
    stall = ($urandom_range(0, 4) == 0);
    flush = ($urandom_range(0, 9) == 0);
    exm_reg_write = 1'($urandom); mwb_reg_write = 1'($urandom);
    exm_rd = 5'($urandom_range(0, 3)); mwb_rd = 5'($urandom_range(0, 3));
    exm_result = $urandom; mwb_result = $urandom;
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      me = q.pop_front();
      chk("alu_a", alu_a, me.a);
      chk("alu_b", alu_b, me.b);
      chk("alu_aluc", 32'(alu_aluc), 32'(me.aluc));
      chk("ex_store_data", ex_store_data, me.sd);
      chk("ex_valid", 32'(ex_valid), 32'(me.v));
      chk("ex_reg_write", 32'(ex_reg_write), 32'(me.rw));
      chk("ex_mem_read", 32'(ex_mem_read), 32'(me.mr));
      chk("ex_mem_write", 32'(ex_mem_write), 32'(me.mw));
      chk("ex_rd", 32'(ex_rd), 32'(me.rd));
      chk("load_use_stall", 32'(load_use_stall), 32'(me.lus));
    end
  end

  initial begin
    held = bubble();
    clear_inputs();
    rst = 1;
    repeat (2) begin
      tick(); rst = 1; push();
      #3 chk("reset_valid", 32'(ex_valid), 32'd0);
    end
    // addi
    tick(); clear_inputs();
    id_valid = 1; id_rs = 1; id_rs_val = 5; id_rt = 2; id_rd = 2;
    id_imm = 16'hFFFF; id_imm_sext = 1; id_alu_src_imm = 1;
    id_aluc = 4'b0010; id_reg_write = 1;
    push();
    tick(); clear_inputs(); push();
    #3 chk("addi_a", alu_a, 32'd5);
    chk("addi_b", alu_b, 32'hFFFF_FFFF);
    chk("addi_valid", 32'(ex_valid), 32'd1);
    // double forward
    tick(); clear_inputs();
    id_valid = 1; id_rs = 3; id_rs_val = 32'h11; push();
    tick(); clear_inputs(); stall = 1;
    exm_reg_write = 1; exm_rd = 3; exm_result = 32'hAA;
    mwb_reg_write = 1; mwb_rd = 3; mwb_result = 32'hBB;
    push();
    #3 chk("dfwd_exm", alu_a, 32'hAA);
    tick(); exm_rd = 0; push();
    #3 chk("dfwd_mwb", alu_a, 32'hBB);
    // srav then sra
    tick(); clear_inputs();
    id_valid = 1; id_rs = 4; id_rs_val = 32'h124; id_shift_var = 1;
    id_aluc = 4'b1100; id_shamt = 7; push();
    tick(); id_shift_var = 0; push();
    #3 chk("srav_a", alu_a, 32'd4);
    tick(); clear_inputs(); push();
    #3 chk("sra_a", alu_a, 32'd7);
    // load-use
    tick(); clear_inputs();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 8;
    id_rs = 1; push();
    tick(); clear_inputs(); id_valid = 1; id_rt = 8; flush = 1; push();
    #3 chk("lu_stall", 32'(load_use_stall), 32'd1);
    tick(); clear_inputs(); push();
    #3 chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
    // stall hold, then stall+flush
    tick(); clear_inputs();
    id_valid = 1; id_rs = 5; id_rs_val = 32'h5555; id_rt = 6;
    id_rt_val = 32'h6666; id_rd = 7; id_reg_write = 1; push();
    repeat (3) begin
      tick(); clear_inputs(); rand_id(); stall = 1; push();
      #3 chk("stall_a", alu_a, 32'h5555);
      chk("stall_b", alu_b, 32'h6666);
      chk("stall_rd", 32'(ex_rd), 32'd7);
    end
    tick(); stall = 1; flush = 1; push();
    tick(); clear_inputs(); push();
    #3 chk("sf_valid", 32'(ex_valid), 32'd0);
    chk("sf_a", alu_a, 32'd0);
    // async reset between edges
    tick(); clear_inputs();
    id_valid = 1; id_rs = 2; id_rs_val = 32'hDEAD; id_aluc = 4'b0101;
    push();
    tick(); clear_inputs(); stall = 1;
    #2 rst = 1; push();
    #1 chk("arst_a", alu_a, 32'd0);
    chk("arst_aluc", 32'(alu_aluc), 32'd0);
    chk("arst_valid", 32'(ex_valid), 32'd0);
    tick(); clear_inputs(); push();
    // sw with MEM/WB-forwarded store data
    tick(); clear_inputs();
    id_valid = 1; id_alu_src_imm = 1; id_imm_sext = 1; id_imm = 16'h0010;
    id_rs = 1; id_rs_val = 32'h100; id_rt = 9; id_rt_val = 32'h999;
    id_mem_write = 1; push();
    tick(); clear_inputs();
    mwb_reg_write = 1; mwb_rd = 9; mwb_result = 32'h1234; push();
    #3 chk("sw_sd", ex_store_data, 32'h1234);
    chk("sw_b", alu_b, 32'h10);
    // randomized traffic
    repeat (400) begin
      tick(); clear_inputs(); rand_inputs(); push();
    end
    tick(); clear_inputs(); push();
    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
